icache_axi_refill_bridge: RTL
=============================

# icache_axi_refill_bridge

Refill bridge between the L1 instruction cache miss interface and an AXI4 read channel, replacing the fixed 64-bit single-outstanding refill path. Supports a parametrised bus data width, up to NumOutstanding concurrent refills tracked by AXI ID, and reports bus errors per refill. It sits between the icache miss/return ports and the core's AXI read master.

## Interface
- AddrWidth, 56: physical address width.
- DataWidth, 64: AXI R data width; power of 2, 32..LineWidth.
- LineWidth, 128: icache line width; power-of-2 multiple of DataWidth, LineWidth/DataWidth <= 256.
- TidWidth, 2: icache transaction ID width.
- IdWidth, 4: AXI ID width; >= clog2(NumOutstanding).
- NumOutstanding, 2: refill tracker entries, 1..8.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  miss request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_paddr_i  in  AddrWidth  miss physical address.
- req_nc_i  in  1  non-cacheable: single-beat fetch.
- req_tid_i  in  TidWidth  icache transaction ID.
- rtrn_valid_o  out  1  one-cycle return pulse.
- rtrn_data_o  out  LineWidth  returned line.
- rtrn_tid_o  out  TidWidth  tid of returned request.
- rtrn_err_o  out  1  any beat had SLVERR/DECERR.
- ar_valid_o, ar_ready_i  out/in  1  AR handshake.
- ar_addr_o  out  AddrWidth  burst address.
- ar_len_o  out  8  beats minus one.
- ar_size_o  out  3  clog2(DataWidth/8).
- ar_burst_o  out  2  always 2'b01 (INCR).
- ar_id_o  out  IdWidth  tracker index, zero-extended.
- r_valid_i, r_ready_o  in/out  1  R handshake.
- r_data_i  in  DataWidth  beat data.
- r_id_i  in  IdWidth  beat ID.
- r_last_i  in  1  last beat.
- r_resp_i  in  2  beat response.
- busy_o  out  1  any tracker allocated or AR pending.

## Operation
- Beats = LineWidth/DataWidth. Tracker entry: valid, tid, nc, beat counter (clog2(Beats) bits, min 1), err, line buffer.
- req_ready_o = AR register empty AND at least one entry free (registered state only, no combinational path from ar_ready_i).
- On accept: allocate lowest-index free entry; load AR register: cacheable addr aligned down to LineWidth/8 bytes, len = Beats-1; nc addr aligned down to DataWidth/8, len = 0; id = entry index.
- AR register holds all fields stable while ar_valid_o && !ar_ready_i; clears on handshake.
- r_ready_o constant 1 out of reset.
- Beat on allocated ID: write r_data_i into word [counter] of that entry's buffer, counter += 1 (wraps modulo Beats), err |= r_resp_i[1]. nc entries always write word 0; other words return 0.
- Beat on unallocated ID: dropped, no state change (bench flags as protocol error).
- Beat with r_last_i: registered return next cycle: rtrn_valid_o=1, data = completed buffer, tid, err; entry freed in that same cycle, counter/err/buffer cleared.
- Return data is in address order regardless of tracker order; completions may return out of request order.

## Timing
- Reset: req_ready_o=0 during reset, all other outputs 0; after release req_ready_o=1, r_ready_o=1.
- Request accept -> ar_valid_o high next cycle. Max request rate one per two cycles.
- Last beat at cycle t -> rtrn_valid_o at t+1 for exactly one cycle.
- Entry freed at t+1 becomes allocatable from t+2 (no same-cycle free/allocate).
- At most one completion per cycle (one R beat per cycle), so no return arbitration.
- All entries busy: req_ready_o=0 until a free cycle; AR may still be pending.
- Reset mid-burst: all trackers, AR register, and return pulse cleared in the cycle after rst_ni low; late beats afterwards are dropped as unallocated.

## Test plan
- Cacheable, DataWidth=64, LineWidth=128: req paddr 0x8000_0018 tid 1 -> AR addr 0x8000_0010 len 1 size 3 id 0; beats 0xA, 0xB last -> next cycle rtrn data {0xB,0xA}, tid 1, err 0.
- Non-cacheable: paddr 0x1004 nc -> AR addr 0x1000 len 0; beat 0x55 last -> rtrn data word0=0x55, others 0.
- Two outstanding: tid 0 (id 0) then tid 2 (id 1); R returns id 1 burst first then id 0 -> two rtrn pulses, tid 2 then tid 0, correct data each; third request stalls req_ready_o=0 until first return +1 cycle.
- Error: second beat r_resp=2'b10 -> rtrn_err_o=1 with full data; next refill err=0.
- Backpressure: ar_ready_i low 5 cycles -> ar_* fields stable, req_ready_o=0 throughout; accept on cycle 6.
- DataWidth=32, LineWidth=128: 4-beat burst, len 3 size 2; reset asserted after beat 2 -> no rtrn, busy_o=0, late beats ignored.

Source files
------------

// File: rtl/icache_axi_refill_bridge_if.sv
// rtl/icache_axi_refill_bridge_if.sv - icache miss/return and AXI read channel bundle for the refill bridge
interface icache_axi_refill_bridge_if #(
    parameter int AddrWidth = 56,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128,
    parameter int TidWidth  = 2,
    parameter int IdWidth   = 4
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_paddr_i;
    logic                 req_nc_i;
    logic [TidWidth-1:0]  req_tid_i;

    logic                 rtrn_valid_o;
    logic [LineWidth-1:0] rtrn_data_o;
    logic [TidWidth-1:0]  rtrn_tid_o;
    logic                 rtrn_err_o;

    logic                 ar_valid_o;
    logic                 ar_ready_i;
    logic [AddrWidth-1:0] ar_addr_o;
    logic [7:0]           ar_len_o;
    logic [2:0]           ar_size_o;
    logic [1:0]           ar_burst_o;
    logic [IdWidth-1:0]   ar_id_o;

    logic                 r_valid_i;
    logic                 r_ready_o;
    logic [DataWidth-1:0] r_data_i;
    logic [IdWidth-1:0]   r_id_i;
    logic                 r_last_i;
    logic [1:0]           r_resp_i;

    // The bridge serves miss requests, so it takes the slave view of the bundle.
    modport slave (
        input  req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
        input  ar_ready_i,
        input  r_valid_i, r_data_i, r_id_i, r_last_i, r_resp_i,
        output req_ready_o,
        output rtrn_valid_o, rtrn_data_o, rtrn_tid_o, rtrn_err_o,
        output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        output r_ready_o
    );

    modport master (
        output req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
        output ar_ready_i,
        output r_valid_i, r_data_i, r_id_i, r_last_i, r_resp_i,
        input  req_ready_o,
        input  rtrn_valid_o, rtrn_data_o, rtrn_tid_o, rtrn_err_o,
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
        input  r_ready_o
    );
endinterface

// File: rtl/icache_axi_refill_bridge.sv
// rtl/icache_axi_refill_bridge.sv - multi-outstanding icache line refill over an AXI4 read channel
module icache_axi_refill_bridge #(
    parameter int AddrWidth      = 56,
    parameter int DataWidth      = 64,
    parameter int LineWidth      = 128,
    parameter int TidWidth       = 2,
    parameter int IdWidth        = 4,
    parameter int NumOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    icache_axi_refill_bridge_if.slave bus,
    output logic                      busy_o
);
    localparam int Beats    = LineWidth / DataWidth;
    localparam int CntWidth = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int IdxWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int SizeVal  = $clog2(DataWidth / 8);
    localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineWidth / 8 - 1);
    localparam logic [AddrWidth-1:0] BeatMask = AddrWidth'(DataWidth / 8 - 1);
    localparam logic [CntWidth-1:0]  LastCnt  = CntWidth'(Beats - 1);

    logic                      run_q;
    logic [NumOutstanding-1:0] ent_valid_q;
    logic [NumOutstanding-1:0] ent_nc_q;
    logic [NumOutstanding-1:0] ent_err_q;
    logic [TidWidth-1:0]       ent_tid_q [NumOutstanding];
    logic [CntWidth-1:0]       ent_cnt_q [NumOutstanding];
    logic [LineWidth-1:0]      ent_buf_q [NumOutstanding];

    logic                      ar_valid_q;
    logic [AddrWidth-1:0]      ar_addr_q;
    logic [7:0]                ar_len_q;
    logic [IdWidth-1:0]        ar_id_q;

    logic                      rtrn_valid_q;
    logic [LineWidth-1:0]      rtrn_data_q;
    logic [TidWidth-1:0]       rtrn_tid_q;
    logic                      rtrn_err_q;
    logic [IdxWidth-1:0]       rtrn_idx_q;

    logic [NumOutstanding-1:0] ent_free;
    logic [IdxWidth-1:0]       alloc_idx;
    logic                      req_ready;
    logic                      req_fire;
    logic [IdxWidth-1:0]       beat_idx;
    logic                      beat_hit;
    logic                      beat_err;
    logic [CntWidth-1:0]       beat_word;
    logic [LineWidth-1:0]      beat_line;

    // The entry whose return pulse is on the bus stays unallocatable for that cycle.
    always_comb begin
        ent_free = ~ent_valid_q;
        if (rtrn_valid_q) begin
            ent_free[rtrn_idx_q] = 1'b0;
        end
        alloc_idx = '0;
        for (int i = NumOutstanding - 1; i >= 0; i--) begin
            if (ent_free[i]) begin
                alloc_idx = IdxWidth'(i);
            end
        end
    end

    assign req_ready = run_q && !ar_valid_q && (|ent_free);
    assign req_fire  = bus.req_valid_i && req_ready;

    assign beat_idx = bus.r_id_i[IdxWidth-1:0];
    assign beat_hit = run_q && bus.r_valid_i && (32'(bus.r_id_i) < NumOutstanding)
                      && ent_valid_q[beat_idx];
    assign beat_err = (bus.r_resp_i == 2'b10) || (bus.r_resp_i == 2'b11);

    // Non-cacheable fetches are single-beat and always land in word 0.
    always_comb begin
        beat_word = ent_nc_q[beat_idx] ? '0 : ent_cnt_q[beat_idx];
        beat_line = ent_buf_q[beat_idx];
        beat_line[beat_word * DataWidth +: DataWidth] = bus.r_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            run_q        <= 1'b0;
            ent_valid_q  <= '0;
            ent_nc_q     <= '0;
            ent_err_q    <= '0;
            for (int i = 0; i < NumOutstanding; i++) begin
                ent_tid_q[i] <= '0;
                ent_cnt_q[i] <= '0;
                ent_buf_q[i] <= '0;
            end
            ar_valid_q   <= 1'b0;
            ar_addr_q    <= '0;
            ar_len_q     <= '0;
            ar_id_q      <= '0;
            rtrn_valid_q <= 1'b0;
            rtrn_data_q  <= '0;
            rtrn_tid_q   <= '0;
            rtrn_err_q   <= 1'b0;
            rtrn_idx_q   <= '0;
        end else begin
            run_q        <= 1'b1;
            rtrn_valid_q <= 1'b0;

            if (ar_valid_q && bus.ar_ready_i) begin
                ar_valid_q <= 1'b0;
                ar_addr_q  <= '0;
                ar_len_q   <= '0;
                ar_id_q    <= '0;
            end

            if (req_fire) begin
                ar_valid_q             <= 1'b1;
                ar_addr_q              <= bus.req_nc_i ? (bus.req_paddr_i & ~BeatMask)
                                                       : (bus.req_paddr_i & ~LineMask);
                ar_len_q               <= bus.req_nc_i ? 8'd0 : 8'(Beats - 1);
                ar_id_q                <= IdWidth'(alloc_idx);
                ent_valid_q[alloc_idx] <= 1'b1;
                ent_nc_q[alloc_idx]    <= bus.req_nc_i;
                ent_tid_q[alloc_idx]   <= bus.req_tid_i;
            end

            if (beat_hit) begin
                if (bus.r_last_i) begin
                    rtrn_valid_q          <= 1'b1;
                    rtrn_data_q           <= beat_line;
                    rtrn_tid_q            <= ent_tid_q[beat_idx];
                    rtrn_err_q            <= ent_err_q[beat_idx] | beat_err;
                    rtrn_idx_q            <= beat_idx;
                    ent_valid_q[beat_idx] <= 1'b0;
                    ent_err_q[beat_idx]   <= 1'b0;
                    ent_cnt_q[beat_idx]   <= '0;
                    ent_buf_q[beat_idx]   <= '0;
                end else begin
                    ent_buf_q[beat_idx]   <= beat_line;
                    ent_err_q[beat_idx]   <= ent_err_q[beat_idx] | beat_err;
                    ent_cnt_q[beat_idx]   <= (ent_cnt_q[beat_idx] == LastCnt) ? '0
                                             : ent_cnt_q[beat_idx] + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.rtrn_valid_o = rtrn_valid_q;
    assign bus.rtrn_data_o  = rtrn_data_q;
    assign bus.rtrn_tid_o   = rtrn_tid_q;
    assign bus.rtrn_err_o   = rtrn_err_q;
    assign bus.ar_valid_o   = ar_valid_q;
    assign bus.ar_addr_o    = ar_addr_q;
    assign bus.ar_len_o     = ar_len_q;
    assign bus.ar_size_o    = run_q ? 3'(SizeVal) : 3'd0;
    assign bus.ar_burst_o   = run_q ? 2'b01 : 2'b00;
    assign bus.ar_id_o      = ar_id_q;
    assign bus.r_ready_o    = run_q;
    assign busy_o           = (|ent_valid_q) || ar_valid_q;
endmodule
